mips_multicycle_core: RTL

- Next-generation MIPS core: a multicycle FSM datapath that replaces the single-cycle core.
- Uses one unified instruction/data memory port with a req/ready handshake, so it tolerates variable memory wait states.
- Adds an illegal-opcode trap with a sticky halt, plus a retired-instruction counter.
- Sits between the top-level testbench/SoC wrapper and a single shared memory model.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/mips_regfile.sv | 19 +
 rtl/mips_multicycle_core.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU control encoding, FSM states and decode helpers
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RTYPE_EX, S_ALU_WB, S_MEMADR, S_MEMREAD, S_MEM_WB,
    S_MEMWRITE, S_BEQ, S_ADDI_EX, S_ADDI_WB, S_JUMP, S_RETIRE, S_TRAP
  } state_t;
  function automatic logic [31:0] sext(input logic [15:0] i);
    return {{16{i[15]}}, i};
  endfunction
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    return op == OP_RTYPE ? fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}
                          : op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction
  function automatic logic [2:0] alu_ctl(input logic [5:0] fn);
    return fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR :
           fn == FN_SLT ? ALU_SLT : ALU_ADD;
  endfunction
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async reads, one sync write, $0 hardwired to zero
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] rf_q [32];
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    else if (we && wa != 5'd0) rf_q[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : rf_q[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : rf_q[ra2];
endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS subset with shared req/ready memory port, illegal-opcode trap and retire counter
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [31:0]      pc,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic halted_q, halted_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic rf_we;
  logic [4:0] rf_wa;
  logic [31:0] rf_wd, rd1, rd2, imm_x, alu_y;
  logic [5:0] op, fn;
  assign op = ir_q[31:26];
  assign fn = ir_q[5:0];
  assign imm_x = sext(ir_q[15:0]);
  mips_regfile u_rf (
    .clk(clk), .reset(reset), .ra1(ir_q[25:21]), .ra2(ir_q[20:16]),
    .we(rf_we), .wa(rf_wa), .wd(rf_wd), .rd1(rd1), .rd2(rd2)
  );
  always_comb begin
    alu_y = a_q + b_q;
    case (alu_ctl(fn))
      ALU_AND: alu_y = a_q & b_q;
      ALU_OR:  alu_y = a_q | b_q;
      ALU_SUB: alu_y = a_q - b_q;
      ALU_SLT: alu_y = {31'b0, $signed(a_q) < $signed(b_q)};
      default: alu_y = a_q + b_q;
    endcase
  end
  assign mem_req = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
  assign mem_we = state_q == S_MEMWRITE;
  assign mem_addr = state_q == S_FETCH ? pc_q : state_q inside {S_MEMREAD, S_MEMWRITE} ? alu_out_q : '0;
  assign mem_wdata = state_q == S_MEMWRITE ? b_q : '0;
  assign pc = pc_q;
  assign halted = halted_q;
  assign retired = retired_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    alu_out_d = alu_out_q;
    mdr_d = mdr_q;
    halted_d = halted_q;
    retired_d = retired_q;
    rf_we = 1'b0;
    rf_wa = ir_q[20:16];
    rf_wd = alu_out_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: if (mem_ready) begin
        ir_d = mem_rdata;
        pc_d = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = rd1;
        b_d = rd2;
        alu_out_d = pc_q + (imm_x << 2);
        state_d = !is_legal(op, fn) ? S_TRAP : op == OP_RTYPE ? S_RTYPE_EX : op == OP_BEQ ? S_BEQ :
                  op == OP_ADDI ? S_ADDI_EX : op == OP_J ? S_JUMP : S_MEMADR;
      end
      S_RTYPE_EX: begin
        alu_out_d = alu_y;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        rf_we = 1'b1;
        rf_wa = ir_q[15:11];
        state_d = S_RETIRE;
      end
      S_MEMADR: begin
        alu_out_d = a_q + imm_x;
        state_d = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: if (mem_ready) begin
        mdr_d = mem_rdata;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        rf_we = 1'b1;
        rf_wd = mdr_q;
        state_d = S_RETIRE;
      end
      S_MEMWRITE: state_d = mem_ready ? S_RETIRE : S_MEMWRITE;
      S_BEQ: begin
        pc_d = a_q == b_q ? alu_out_q : pc_q;
        state_d = S_RETIRE;
      end
      S_ADDI_EX: begin
        alu_out_d = a_q + imm_x;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        rf_we = 1'b1;
        state_d = S_RETIRE;
      end
      S_JUMP: begin
        pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        state_d = S_RETIRE;
      end
      S_RETIRE: begin
        retired_d = retired_q + CNT_ONE;
        state_d = S_FETCH;
      end
      S_TRAP: halted_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      alu_out_q <= '0;
      mdr_q <= '0;
      halted_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q <= mdr_d;
      halted_q <= halted_d;
      retired_q <= retired_d;
    end
  end
endmodule
